// File: rtl/wb_spi_master.sv
// Wishbone-attached 8-bit full-duplex SPI master with CPOL/CPHA/bit-order control.
// One transfer = 16 sclk edges plus one half-period of chip-select hold.
module wb_spi_master #(
  parameter int DIV_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] s_wb_dat_i,
  input  logic [8:0]  s_wb_adr_i,
  input  logic [3:0]  s_wb_sel_i,
  input  logic        s_wb_we_i,
  input  logic        s_wb_cyc_i,
  input  logic        s_wb_stb_i,
  output logic [31:0] s_wb_dat_o,
  output logic        s_wb_ack_o,
  output logic        spi_sclk_o,
  output logic        spi_mosi_o,
  output logic        spi_csn_o,
  input  logic        spi_miso_i,
  output logic        irq_o
);

  typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;
  state_t state, state_next;

  logic             en, cpol, cpha, lsb_first;
  logic [DIV_W-1:0] div, cnt;
  logic [7:0]       tx_data, rx_shift, rx_data, rx_next, rx_capture;
  logic [4:0]       edge_cnt, next_edge;
  logic             rx_valid, err, busy, csn, sclk, mosi, ack;
  logic [31:0]      dat_o, rdata;
  logic [2:0]       reg_sel;
  logic             req, wr, rd, tx_wr, cfg_wr, start, err_set, err_clr, rx_rd, rx_load;
  logic             tick, last_edge, sample_now, shift_now;
  logic             unused_bits;

  function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] i, input logic lsb);
    return lsb ? b[i] : b[3'd7 - i];
  endfunction

  // The ack cycle still carries stb, so it must not count as a new request.
  assign req     = s_wb_stb_i & s_wb_cyc_i & ~ack;
  assign reg_sel = s_wb_adr_i[2:0];
  assign wr      = req & s_wb_we_i & s_wb_sel_i[0];
  assign rd      = req & ~s_wb_we_i;
  assign tx_wr   = wr & (reg_sel == 3'd2);
  assign cfg_wr  = wr & ((reg_sel == 3'd0) | (reg_sel == 3'd1));
  assign start   = tx_wr & en & ~busy;
  assign err_set = (tx_wr | cfg_wr) & busy;
  assign err_clr = wr & (reg_sel == 3'd4) & s_wb_dat_i[2];
  assign rx_rd   = rd & (reg_sel == 3'd3);

  assign tick       = (cnt == '0);
  assign next_edge  = edge_cnt + 5'd1;
  assign last_edge  = (next_edge == 5'd16);
  assign sample_now = next_edge[0] ^ cpha;
  assign shift_now  = ~sample_now & ~last_edge;
  assign rx_next    = lsb_first ? {spi_miso_i, rx_shift[7:1]} : {rx_shift[6:0], spi_miso_i};
  assign rx_capture = sample_now ? rx_next : rx_shift;

  assign unused_bits = &{1'b0, s_wb_sel_i[3:1], s_wb_adr_i[8:3], s_wb_dat_i[31:8]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = XFER;
      XFER:    if (tick && last_edge) state_next = HOLD;
      HOLD:    if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    csn     = (state == IDLE);
    rx_load = (state == XFER) && tick && last_edge;
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      3'd0:    rdata[3:0] = {lsb_first, cpha, cpol, en};
      3'd1:    rdata[DIV_W-1:0] = div;
      3'd3:    rdata[7:0] = rx_data;
      3'd4:    rdata[2:0] = {err, rx_valid, busy};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack <= 1'b0;
      dat_o <= '0;
      {lsb_first, cpha, cpol, en} <= '0;
      div <= '0;
      err <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      ack   <= req;
      dat_o <= rd ? rdata : '0;
      if (wr && reg_sel == 3'd0 && !busy) {lsb_first, cpha, cpol, en} <= s_wb_dat_i[3:0];
      if (wr && reg_sel == 3'd1 && !busy) div <= s_wb_dat_i[DIV_W-1:0];
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      if (rx_load)    rx_valid <= 1'b1;
      else if (rx_rd) rx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt      <= '0;
      edge_cnt <= '0;
      tx_data  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sclk <= cpol;
          if (start) begin
            cnt      <= div;
            edge_cnt <= '0;
            tx_data  <= s_wb_dat_i[7:0];
            rx_shift <= '0;
            if (!cpha) mosi <= pick_bit(s_wb_dat_i[7:0], 3'd0, lsb_first);
          end
        end
        XFER: begin
          if (tick) begin
            cnt      <= div;
            sclk     <= ~sclk;
            edge_cnt <= next_edge;
            rx_shift <= rx_capture;
            // Bit index of the edge about to occur is edge/2 for both phases.
            if (shift_now) mosi <= pick_bit(tx_data, next_edge[3:1], lsb_first);
            if (last_edge) rx_data <= rx_capture;
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        HOLD: if (!tick) cnt <= cnt - DIV_W'(1);
        default: ;
      endcase
    end
  end

  assign s_wb_ack_o = ack;
  assign s_wb_dat_o = dat_o;
  assign spi_sclk_o = sclk;
  assign spi_mosi_o = mosi;
  assign spi_csn_o  = csn;
  assign irq_o      = rx_valid;

endmodule
